w21_col_mac: RTL and testbench

- Read-side consumer for one column of layer-2.1 weight ROMs; one instance per column.
- Drives the ROM address (`adrs_clm`) sequentially from 0 to N_IN-1.
- Multiplies each returned signed weight by one streamed input activation and accumulates the dot product.
- Presents one scaled, saturated neuron result through a valid/ready handshake.

---
 rtl/w21_mac_pkg.sv | 50 +++++
 rtl/w21_sat_shift.sv | 45 ++++
 rtl/w21_col_mac.sv | 174 +++++++++++++++++
 tb/tb_w21_col_mac.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/w21_mac_pkg.sv
// ============================================================================
// Module  : w21_mac_pkg
// Brief   : Shared types, default widths and the saturation helper for the
//           layer-2.1 column multiply-accumulate block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package w21_mac_pkg;

    // Column FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default geometry of one layer-2.1 weight column
    localparam int C_N_IN   = 300;
    localparam int C_ADDR_W = 9;
    localparam int C_W_W    = 21;
    localparam int C_X_W    = 16;
    localparam int C_ACC_W  = 48;
    localparam int C_FRAC   = 0;
    localparam int C_Y_W    = 24;

    // Clamp a sign-extended accumulator value into the signed range of a
    // yw-bit result. The value travels in a 64-bit container so that one
    // function serves every accumulator/output width pairing up to 64 bits.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 yw
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (yw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/w21_sat_shift.sv
// ============================================================================
// Module  : w21_sat_shift
// Brief   : Combinational output stage: arithmetic right shift by FRAC,
//           saturation to the signed Y_W range, optional ReLU.
//           Build option: define W21_COL_MAC_RELU_EN to clamp negative
//           results to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module w21_sat_shift
    import w21_mac_pkg::*;
#(
    parameter int ACC_W = C_ACC_W,
    parameter int FRAC  = C_FRAC,
    parameter int Y_W   = C_Y_W
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [Y_W-1:0]   y_o
);

    logic signed [ACC_W-1:0] w_shifted;
    logic signed [63:0]      w_wide;
    logic signed [63:0]      w_sat;
    logic                    w_unused;

    // Scale, widen with sign, clamp, then optionally rectify
    always_comb begin
        w_shifted = $signed(acc_i) >>> FRAC;
        w_wide    = 64'(w_shifted);
        w_sat     = saturate(w_wide, Y_W);
`ifdef W21_COL_MAC_RELU_EN
        if (w_sat < 64'sd0) begin
            w_sat = 64'sd0;
        end
`endif
        y_o = w_sat[Y_W-1:0];
    end

    // Upper container bits are redundant sign copies after saturation
    assign w_unused = ^w_sat[63:Y_W];

endmodule

`default_nettype wire

// File: rtl/w21_col_mac.sv
// ============================================================================
// Module  : w21_col_mac
// Brief   : One-column consumer of the layer-2.1 weight ROM. Walks the ROM
//           address 0..N_IN-1, multiplies each weight by a streamed
//           activation, accumulates the dot product and hands out one
//           scaled, saturated result over a valid/ready handshake.
//           Build option: W21_COL_MAC_RELU_EN (ReLU on the result, handled
//           inside w21_sat_shift).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module w21_col_mac
    import w21_mac_pkg::*;
#(
    parameter int N_IN   = C_N_IN,
    parameter int ADDR_W = C_ADDR_W,
    parameter int W_W    = C_W_W,
    parameter int X_W    = C_X_W,
    parameter int ACC_W  = C_ACC_W,
    parameter int FRAC   = C_FRAC,
    parameter int Y_W    = C_Y_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [X_W-1:0]    x_data,
    input  logic              x_valid,
    output logic              x_ready,
    output logic [ADDR_W-1:0] adrs_clm,
    input  logic [W_W-1:0]    w_data,
    output logic [Y_W-1:0]    y_out,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              busy
);

    // Full-precision product width; the accumulator must be strictly wider
    // so the product can be sign-extended into it.
    localparam int              PW     = W_W + X_W;
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [ADDR_W-1:0]   adrs_q;
    logic                x_ready_q;
    logic                busy_q;
    logic [Y_W-1:0]      y_q;
    logic                y_valid_q;
    logic [PW-1:0]       prod_q;
    logic                prod_v_q;
    logic [ACC_W-1:0]    acc_q;

    // ------------------------------------------------------------------
    // Next-state / combinational helpers
    // ------------------------------------------------------------------
    logic                w_accept;
    logic signed [PW-1:0] w_x_ext;
    logic signed [PW-1:0] w_w_ext;
    logic [PW-1:0]       prod_d;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    acc_d;
    logic [Y_W-1:0]      w_y_sat;

    // An activation is consumed only while running with the ready flag up
    assign w_accept = (state_q == RUN) && x_ready_q && x_valid;

    // Signed product of the current activation and the ROM word it meets
    always_comb begin
        w_x_ext = {{W_W{x_data[X_W-1]}}, x_data};
        w_w_ext = {{X_W{w_data[W_W-1]}}, w_data};
        prod_d  = w_x_ext * w_w_ext;
    end

    // Accumulate stage runs one cycle behind the accept that made the product
    always_comb begin
        w_prod_ext = {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};
        acc_d      = prod_v_q ? (acc_q + w_prod_ext) : acc_q;
    end

    // Product pipeline register and dot-product accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            prod_v_q <= w_accept;
            if (w_accept) begin
                prod_q <= prod_d;
            end
            if ((state_q == IDLE) && start) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    // Output scaling and saturation
    w21_sat_shift #(
        .ACC_W (ACC_W),
        .FRAC  (FRAC),
        .Y_W   (Y_W)
    ) u_sat_shift (
        .acc_i (acc_q),
        .y_o   (w_y_sat)
    );

    // Column sequencer: address walk, drain, result hold and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            adrs_q    <= '0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        adrs_q    <= '0;
                        x_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (adrs_q == C_LAST) begin
                            // Last index consumed: park the address at 0
                            // and stop accepting while the tail product lands.
                            state_q   <= DRAIN;
                            adrs_q    <= '0;
                            x_ready_q <= 1'b0;
                        end else begin
                            adrs_q <= adrs_q + C_ONE;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                end
                DONE: begin
                    if (!y_valid_q) begin
                        // Accumulator is final here; capture once and hold
                        y_q       <= w_y_sat;
                        y_valid_q <= 1'b1;
                    end else if (y_ready) begin
                        y_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign x_ready  = x_ready_q;
    assign adrs_clm = adrs_q;
    assign y_out    = y_q;
    assign y_valid  = y_valid_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_w21_col_mac.sv
// ============================================================================
// Module  : tb_w21_col_mac
// Brief   : Directed self-checking bench for w21_col_mac with a local model
//           of a weight column ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_w21_col_mac;

`ifdef W21_COL_MAC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x_data;
    logic        x_valid;
    logic        x_ready;
    logic [8:0]  adrs_clm;
    logic [20:0] w_data;
    logic [23:0] y_out;
    logic        y_valid;
    logic        y_ready;
    logic        busy;

    logic signed [15:0] xv [300];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    w21_col_mac #(
        .N_IN   (300),
        .ADDR_W (9),
        .W_W    (21),
        .X_W    (16),
        .ACC_W  (48),
        .FRAC   (0),
        .Y_W    (24)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .adrs_clm (adrs_clm),
        .w_data   (w_data),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .busy     (busy)
    );

    // Column ROM model: known anchor weights plus a deterministic filler
    function automatic longint wrom(input int a);
        case (a)
            0:       return 310;
            1:       return -560;
            207:     return 1727;
            default: return longint'(((a * 7919 + 13) % 4001) - 2000);
        endcase
    endfunction

    always_comb w_data = 21'(wrom(int'(adrs_clm)));

    // Reference dot product, saturated to 24 bits, optional ReLU
    function automatic longint exp_y();
        longint s;
        s = 0;
        for (int i = 0; i < 300; i++) s += longint'(xv[i]) * wrom(i);
        if (s > 64'sd8388607) s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        if (RELU && s < 0) s = 0;
        return s;
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_x();
        for (int i = 0; i < 300; i++) xv[i] = 16'sd0;
    endtask

    // One full column: start, stream activations, hold result, handshake
    task automatic run_col(input string tag, input bit gaps, input int hold,
                           output longint y_res, output int lat);
        int          idx;
        int          cnt;
        int          maxa;
        logic        xr;
        logic [23:0] y0;
        bit          done;
        idx = 0; cnt = 0; maxa = 0; lat = -1; y_res = 0; done = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!done && cnt < 1000) begin
            @(negedge clk);
            xr = x_ready;
            if (xr && idx < 300 && (!gaps || $urandom_range(0, 2) != 0)) begin
                x_valid = 1'b1;
                x_data  = xv[idx];
            end else begin
                x_valid = 1'b0;
                x_data  = 16'($urandom);
            end
            start = gaps && (cnt == 40 || cnt == 41);
            @(posedge clk); cnt++;
            #1;
            if (x_valid && xr) idx++;
            if (int'(adrs_clm) > maxa) maxa = int'(adrs_clm);
            if (y_valid) done = 1'b1;
        end
        start = 1'b0; x_valid = 1'b0;
        chk({tag, " done"}, longint'(done), 1);
        if (!done) return;
        lat   = cnt;
        y0    = y_out;
        y_res = longint'($signed(y_out));
        chk({tag, " adrs<=299"}, longint'(maxa <= 299), 1);
        chk({tag, " accepted"}, idx, 300);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); y_ready = 1'b0; start = (k == 2);
            @(posedge clk); #1;
            chk({tag, " hold y"}, longint'($signed(y_out)), longint'($signed(y0)));
            chk({tag, " hold valid"}, longint'(y_valid), 1);
        end
        @(negedge clk); y_ready = 1'b1; start = 1'b0;
        @(posedge clk); #1 y_ready = 1'b0;
        chk({tag, " valid drop"}, longint'(y_valid), 0);
        chk({tag, " idle busy"}, longint'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 required");
        $fatal(1);
    end

    initial begin
        longint y;
        int     lat;
        int     cnt;
        rst = 1'b1; start = 1'b0; x_valid = 1'b0; y_ready = 1'b0; x_data = '0;
        clear_x();
        #12;
        chk("rst y_valid", longint'(y_valid), 0);
        chk("rst busy", longint'(busy), 0);
        chk("rst adrs", longint'(adrs_clm), 0);
        chk("rst x_ready", longint'(x_ready), 0);
        chk("rst y_out", longint'(y_out), 0);
        @(negedge clk); rst = 1'b0;

        // All-zero activations, latency from the start edge
        run_col("zero", 1'b0, 0, y, lat);
        chk("zero y", y, 0);
        chk("zero latency", lat, 302);

        // Single unit activation picks out weight[0]
        xv[0] = 16'sd1;
        run_col("x0", 1'b0, 0, y, lat);
        chk("x0 y", y, 310);

        // Add weight[1] = -560
        xv[1] = 16'sd1;
        run_col("x01", 1'b0, 0, y, lat);
        chk("x01 y", y, RELU ? 0 : -250);

        // Positive and negative saturation on weight 1727
        clear_x();
        xv[207] = 16'sd32767;
        run_col("satp", 1'b0, 0, y, lat);
        chk("satp y", y, 8388607);
        xv[207] = -16'sd32768;
        run_col("satn", 1'b0, 0, y, lat);
        chk("satn y", y, RELU ? 0 : -8388608);

        // Random activations, gapped stream, held result, stray starts
        for (int i = 0; i < 300; i++) xv[i] = 16'(int'($urandom_range(0, 400)) - 200);
        run_col("rand", 1'b1, 5, y, lat);
        chk("rand y", y, exp_y());

        // Abort mid-column, then a clean column must not see leftovers
        for (int i = 0; i < 300; i++) xv[i] = 16'sd5;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        while (adrs_clm != 9'd100 && cnt < 400) begin
            @(negedge clk); x_valid = 1'b1; x_data = 16'sd5;
            @(posedge clk); #1 cnt++;
        end
        chk("abort reached 100", longint'(adrs_clm), 100);
        #2 rst = 1'b1;
        #1;
        chk("abort y_valid", longint'(y_valid), 0);
        chk("abort busy", longint'(busy), 0);
        chk("abort adrs", longint'(adrs_clm), 0);
        @(negedge clk); rst = 1'b0; x_valid = 1'b0;
        clear_x();
        xv[0] = 16'sd1;
        run_col("post", 1'b0, 0, y, lat);
        chk("post y", y, 310);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
